// File: rtl/multicycle_control.sv
// Purpose: main control FSM of the multicycle datapath (fetch/decode/execute/mem/writeback).
// Latency: lw 5, sw/R-type/andi 4, beq/j 3 cycles from FETCH to retire with memory always ready.
// Backpressure: FETCH/MEMRD/MEMWR hold on mem_ready=0; MEM_TIMEOUT consecutive stalls trap.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [2:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXE   = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXE   = 4'd11,
        S_IWB    = 4'd12,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic             is_lw;
    logic             mem_wait;
    logic             timeout;

    // Registered qualifiers for the outputs that must also see mem_ready this cycle.
    logic fetch_q;
    logic jump_q;
    logic memwr_q;
    logic retire_q;

    // Stall bookkeeping and next-state selection; a timeout overrides any normal transition.
    always_comb begin
        mem_wait = ((cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR)) && !mem_ready;
        timeout  = mem_wait && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
        nxt_cnt  = (mem_wait && !timeout) ? wait_cnt + CNT_W'(1) : '0;
        nxt      = cur;
        case (cur)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:    nxt = S_REXE;
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_BEQ:      nxt = S_BEQ;
                    OP_J:        nxt = S_JUMP;
                    OP_ANDI:     nxt = S_IEXE;
                    default:     nxt = S_TRAP;
                endcase
            end
            S_MEMADR: nxt = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH;
            S_REXE:   nxt = S_RWB;
            S_RWB:    nxt = S_FETCH;
            S_BEQ:    nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_IEXE:   nxt = S_IWB;
            S_IWB:    nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_TRAP;
        endcase
        if (timeout) nxt = S_TRAP;
    end

    // State, wait counter, lw/sw latch and outputs registered from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= S_IDLE;
            wait_cnt    <= '0;
            is_lw       <= 1'b0;
            aluop       <= 3'b000;
            alusrca     <= 1'b0;
            alusrcb     <= 2'b00;
            pcsrc       <= 2'b00;
            pcwritecond <= 1'b0;
            iord        <= 1'b0;
            memread     <= 1'b0;
            memwrite    <= 1'b0;
            regdst      <= 1'b0;
            memtoreg    <= 1'b0;
            regwrite    <= 1'b0;
            trap        <= 1'b0;
            fetch_q     <= 1'b0;
            jump_q      <= 1'b0;
            memwr_q     <= 1'b0;
            retire_q    <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= nxt_cnt;
            if (cur == S_DECODE) is_lw <= (opcode == OP_LW);
            aluop       <= 3'b000;
            alusrca     <= 1'b0;
            alusrcb     <= 2'b00;
            pcsrc       <= 2'b00;
            pcwritecond <= 1'b0;
            iord        <= 1'b0;
            memread     <= 1'b0;
            memwrite    <= 1'b0;
            regdst      <= 1'b0;
            memtoreg    <= 1'b0;
            regwrite    <= 1'b0;
            trap        <= 1'b0;
            fetch_q     <= 1'b0;
            jump_q      <= 1'b0;
            memwr_q     <= 1'b0;
            retire_q    <= 1'b0;
            case (nxt)
                S_FETCH:  begin memread <= 1'b1; alusrcb <= 2'b01; fetch_q <= 1'b1; end
                S_DECODE: alusrcb <= 2'b11;
                S_MEMADR: begin alusrca <= 1'b1; alusrcb <= 2'b10; end
                S_MEMRD:  begin memread <= 1'b1; iord <= 1'b1; end
                S_MEMWB:  begin regwrite <= 1'b1; memtoreg <= 1'b1; retire_q <= 1'b1; end
                S_MEMWR:  begin memwrite <= 1'b1; iord <= 1'b1; memwr_q <= 1'b1; end
                S_REXE:   begin alusrca <= 1'b1; aluop <= 3'b100; end
                S_RWB:    begin regwrite <= 1'b1; regdst <= 1'b1; retire_q <= 1'b1; end
                S_BEQ: begin
                    alusrca     <= 1'b1;
                    aluop       <= 3'b001;
                    pcwritecond <= 1'b1;
                    pcsrc       <= 2'b01;
                    retire_q    <= 1'b1;
                end
                S_JUMP:   begin jump_q <= 1'b1; pcsrc <= 2'b10; retire_q <= 1'b1; end
                S_IEXE:   begin alusrca <= 1'b1; alusrcb <= 2'b10; aluop <= 3'b110; end
                S_IWB:    begin regwrite <= 1'b1; retire_q <= 1'b1; end
                S_TRAP:   trap <= 1'b1;
                default:  ;
            endcase
        end
    end

    // Handshake-qualified enables: the fetch and the store complete only when memory is ready.
    assign pcwrite = jump_q | (fetch_q & mem_ready);
    assign irwrite = fetch_q & mem_ready;
    assign retire  = retire_q | (memwr_q & mem_ready);
    assign state   = cur;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int TO1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default timeout)
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [2:0] aluop;
    logic       alusrca, pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, retire, trap;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .retire(retire), .trap(trap), .state(state)
    );

    // Short-timeout DUT
    logic       b_rst_n;
    logic [5:0] b_opcode;
    logic       b_mem_ready;
    logic [2:0] b_aluop;
    logic       b_alusrca, b_pcwrite, b_pcwritecond, b_iord, b_memread, b_memwrite, b_irwrite;
    logic       b_regdst, b_memtoreg, b_regwrite, b_retire, b_trap;
    logic [1:0] b_alusrcb, b_pcsrc;
    logic [3:0] b_state;

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_to4 (
        .clk(clk), .rst_n(b_rst_n), .opcode(b_opcode), .mem_ready(b_mem_ready),
        .aluop(b_aluop), .alusrca(b_alusrca), .alusrcb(b_alusrcb), .pcsrc(b_pcsrc),
        .pcwrite(b_pcwrite), .pcwritecond(b_pcwritecond), .iord(b_iord), .memread(b_memread),
        .memwrite(b_memwrite), .irwrite(b_irwrite), .regdst(b_regdst), .memtoreg(b_memtoreg),
        .regwrite(b_regwrite), .retire(b_retire), .trap(b_trap), .state(b_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected outputs for a state, straight from the per-state output table.
    function automatic logic [22:0] exp_out(input int st, input logic rdy);
        logic [2:0] op3;
        logic [1:0] asb, psrc;
        logic asa, pcw, pcwc, ior, mrd, mwr, irw, rdst, m2r, rw, ret, trp;
        op3 = 3'b000; asb = 2'b00; psrc = 2'b00;
        asa = 0; pcw = 0; pcwc = 0; ior = 0; mrd = 0; mwr = 0; irw = 0;
        rdst = 0; m2r = 0; rw = 0; ret = 0; trp = 0;
        case (st)
            1:  begin mrd = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mrd = 1; ior = 1; end
            5:  begin rw = 1; m2r = 1; ret = 1; end
            6:  begin mwr = 1; ior = 1; ret = rdy; end
            7:  begin asa = 1; op3 = 3'b100; end
            8:  begin rw = 1; rdst = 1; ret = 1; end
            9:  begin asa = 1; op3 = 3'b001; pcwc = 1; psrc = 2'b01; ret = 1; end
            10: begin pcw = 1; psrc = 2'b10; ret = 1; end
            11: begin asa = 1; asb = 2'b10; op3 = 3'b110; end
            12: begin rw = 1; ret = 1; end
            15: trp = 1;
            default: ;
        endcase
        return {op3, asa, asb, psrc, pcw, pcwc, ior, mrd, mwr, irw, rdst, m2r, rw, ret, trp, 4'(st)};
    endfunction

    logic [22:0] dut_vec;
    assign dut_vec = {aluop, alusrca, alusrcb, pcsrc, pcwrite, pcwritecond, iord, memread,
                      memwrite, irwrite, regdst, memtoreg, regwrite, retire, trap, state};

    // Reference model: current step plus the queue of steps left in the instruction.
    int m_state = 0;
    int m_wait  = 0;
    int m_path[$];

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_path.delete();
    endtask

    task automatic model_edge(input logic rst, input logic rdy, input logic [5:0] op);
        if (!rst) begin
            model_reset();
        end else if (m_state == 15) begin
            m_state = 15;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if ((m_state == 1 || m_state == 4 || m_state == 6) && !rdy) begin
            m_wait++;
            if (m_wait >= TO1) begin
                m_state = 15;
                m_path.delete();
            end
        end else begin
            m_wait = 0;
            if (m_state == 1) begin
                m_state = 2;
            end else if (m_state == 2) begin
                m_path.delete();
                case (op)
                    6'h00: m_path = '{7, 8};
                    6'h23: m_path = '{3, 4, 5};
                    6'h2B: m_path = '{3, 6};
                    6'h04: m_path = '{9};
                    6'h02: m_path = '{10};
                    6'h0C: m_path = '{11, 12};
                    default: m_path = '{15};
                endcase
                m_state = m_path.pop_front();
            end else if (m_path.size() == 0) begin
                m_state = 1;
            end else begin
                m_state = m_path.pop_front();
            end
        end
    endtask

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [5:0] op;
        logic [3:0] st;
        logic [2:0] alu;
        logic       pcw;
        logic       rw;
        logic       mr;
        logic       ret;
        logic       trp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rs, input logic rd, input logic [5:0] op, input logic [3:0] st,
                       input logic [2:0] alu, input logic pcw, input logic rw, input logic mr,
                       input logic ret, input logic trp);
        vec_t v;
        v.rst = rs; v.rdy = rd; v.op = op; v.st = st; v.alu = alu;
        v.pcw = pcw; v.rw = rw; v.mr = mr; v.ret = ret; v.trp = trp;
        tbl.push_back(v);
    endtask

    logic [5:0] legal [6];
    int         trap_age;
    int         burst;
    int         idx;

    initial begin
        legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h0C};
        rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b1;
        b_rst_n = 1'b0; b_opcode = 6'h00; b_mem_ready = 1'b0;

        //   rst rdy op     st  alu pcw rw mr ret trp
        add(0, 1, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h00, 1,  0, 1, 0, 1, 0, 0);
        add(1, 1, 6'h00, 2,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h00, 7,  4, 0, 0, 0, 0, 0);
        add(1, 1, 6'h00, 8,  0, 0, 1, 0, 1, 0);
        add(1, 1, 6'h0C, 1,  0, 1, 0, 1, 0, 0);
        add(1, 1, 6'h0C, 2,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h0C, 11, 6, 0, 0, 0, 0, 0);
        add(1, 1, 6'h0C, 12, 0, 0, 1, 0, 1, 0);
        add(1, 1, 6'h04, 1,  0, 1, 0, 1, 0, 0);
        add(1, 1, 6'h04, 2,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h04, 9,  1, 0, 0, 0, 1, 0);
        add(1, 1, 6'h02, 1,  0, 1, 0, 1, 0, 0);
        add(1, 1, 6'h02, 2,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h02, 10, 0, 1, 0, 0, 1, 0);
        add(1, 0, 6'h23, 1,  0, 0, 0, 1, 0, 0);
        add(1, 1, 6'h23, 1,  0, 1, 0, 1, 0, 0);
        add(1, 1, 6'h23, 2,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h00, 3,  0, 0, 0, 0, 0, 0);
        add(1, 0, 6'h00, 4,  0, 0, 0, 1, 0, 0);
        add(1, 0, 6'h00, 4,  0, 0, 0, 1, 0, 0);
        add(1, 0, 6'h00, 4,  0, 0, 0, 1, 0, 0);
        add(1, 1, 6'h00, 4,  0, 0, 0, 1, 0, 0);
        add(1, 1, 6'h00, 5,  0, 0, 1, 0, 1, 0);
        add(1, 1, 6'h2B, 1,  0, 1, 0, 1, 0, 0);
        add(1, 1, 6'h2B, 2,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h00, 3,  0, 0, 0, 0, 0, 0);
        add(1, 0, 6'h00, 6,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h00, 6,  0, 0, 0, 0, 1, 0);
        add(1, 1, 6'h3F, 1,  0, 1, 0, 1, 0, 0);
        add(1, 1, 6'h3F, 2,  0, 0, 0, 0, 0, 0);
        add(1, 1, 6'h3F, 15, 0, 0, 0, 0, 0, 1);

        // Directed instruction sequences, one row per cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst; mem_ready = tbl[i].rdy; opcode = tbl[i].op;
            #2;
            check($sformatf("row%0d", i),
                  {20'd0, state, aluop, pcwrite, regwrite, memread, retire, trap},
                  {20'd0, tbl[i].st, tbl[i].alu, tbl[i].pcw, tbl[i].rw, tbl[i].mr, tbl[i].ret, tbl[i].trp});
        end

        // TRAP is sticky for 20 cycles whatever the inputs do.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom_range(0, 63));
            #2;
            check("trap_hold", {27'd0, trap, state}, {27'd0, 1'b1, 4'd15});
            check("trap_quiet", {27'd0, pcwrite, irwrite, memwrite, regwrite, retire}, 32'd0);
        end

        // Reset leaves TRAP immediately and keeps every write enable low.
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1;
        #2;
        check("trap_reset", {27'd0, trap, state}, 32'd0);
        check("reset_we", {27'd0, pcwrite, pcwritecond, irwrite, memwrite, regwrite}, 32'd0);

        // Timeout at 4 stalled fetch cycles, then ready arriving on the 4th stall cycle.
        for (int variant = 0; variant < 2; variant++) begin
            @(negedge clk);
            b_rst_n = 1'b0; b_mem_ready = 1'b0;
            @(negedge clk);
            b_rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                b_mem_ready = (variant == 1) && (i == 3);
                #2;
                check($sformatf("to4_v%0d_fetch%0d", variant, i), {28'd0, b_state}, 32'd1);
            end
            @(negedge clk);
            b_mem_ready = 1'b1;
            #2;
            check($sformatf("to4_v%0d_after", variant), {27'd0, b_trap, b_state},
                  (variant == 1) ? 32'd2 : {27'd0, 1'b1, 4'd15});
        end

        // Randomized run against the reference model, with resets and stall bursts.
        model_reset();
        trap_age = 0;
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n = !(n == 0 || $urandom_range(0, 199) == 0 || (m_state == 15 && trap_age > 3));
            if (burst > 0) begin
                mem_ready = 1'b0;
                burst--;
            end else begin
                mem_ready = ($urandom_range(0, 99) < 75);
                if ($urandom_range(0, 59) == 0) burst = $urandom_range(12, 20);
            end
            idx = $urandom_range(0, 24);
            opcode = (idx < 24) ? legal[idx % 6] : 6'($urandom_range(0, 63));
            if (!rst_n) model_reset();
            #2;
            check("random_vec", {9'd0, dut_vec}, {9'd0, exp_out(m_state, mem_ready)});
            @(posedge clk);
            model_edge(rst_n, mem_ready, opcode);
            trap_age = (m_state == 15) ? trap_age + 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
